// File: rtl/axi_memtest_pkg.sv
// Shared types, AXI encodings and the address-derived test pattern for the
// AXI memory-test initiator.
package axi_memtest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

    // Data stored at byte address addr: inverted address in the upper word.
    function automatic logic [63:0] pattern(input logic [31:0] addr);
        return {~addr, addr};
    endfunction

endpackage

// File: rtl/axi_memtest_master_if.sv
// AXI4 channel bundle between the memory-test initiator and a RAM/crossbar
// slave port; signal prefixes follow the initiator's point of view.
interface axi_memtest_master_if #(
    parameter int ID_WIDTH = 6
) ();
    logic [ID_WIDTH-1:0] o_awid;
    logic [31:0]         o_awaddr;
    logic [7:0]          o_awlen;
    logic [2:0]          o_awsize;
    logic [1:0]          o_awburst;
    logic                o_awvalid;
    logic                i_awready;

    logic [63:0]         o_wdata;
    logic [7:0]          o_wstrb;
    logic                o_wlast;
    logic                o_wvalid;
    logic                i_wready;

    logic [ID_WIDTH-1:0] i_bid;
    logic [1:0]          i_bresp;
    logic                i_bvalid;
    logic                o_bready;

    logic [ID_WIDTH-1:0] o_arid;
    logic [31:0]         o_araddr;
    logic [7:0]          o_arlen;
    logic [2:0]          o_arsize;
    logic [1:0]          o_arburst;
    logic                o_arvalid;
    logic                i_arready;

    logic [ID_WIDTH-1:0] i_rid;
    logic [63:0]         i_rdata;
    logic [1:0]          i_rresp;
    logic                i_rlast;
    logic                i_rvalid;
    logic                o_rready;

    modport master (
        output o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
        input  i_awready,
        output o_wdata, o_wstrb, o_wlast, o_wvalid,
        input  i_wready,
        input  i_bid, i_bresp, i_bvalid,
        output o_bready,
        output o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid,
        input  i_arready,
        input  i_rid, i_rdata, i_rresp, i_rlast, i_rvalid,
        output o_rready
    );

    modport slave (
        input  o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
        output i_awready,
        input  o_wdata, o_wstrb, o_wlast, o_wvalid,
        output i_wready,
        output i_bid, i_bresp, i_bvalid,
        input  o_bready,
        input  o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid,
        output i_arready,
        output i_rid, i_rdata, i_rresp, i_rlast, i_rvalid,
        input  o_rready
    );
endinterface

// File: rtl/axi_memtest_master.sv
// AXI4 self-test initiator: writes an address-derived pattern over a region in
// INCR bursts, reads it back, and reports error count and first failing address.
module axi_memtest_master
    import axi_memtest_pkg::*;
#(
    parameter int ID_WIDTH  = 6,
    parameter int BURST_LEN = 8,
    parameter int AXI_ID    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_base,
    input  logic [15:0] i_nbursts,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_err_count,
    output logic [31:0] o_first_err_addr,
    axi_memtest_master_if.master axi
);

    localparam int                  ALIGN_BITS  = $clog2(BURST_LEN * 8);
    localparam logic [31:0]         ALIGN_MASK  = ~((32'd1 << ALIGN_BITS) - 32'd1);
    localparam logic [31:0]         BEAT_BYTES  = 32'd8;
    localparam logic [7:0]          LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [ID_WIDTH-1:0] ID_VAL      = ID_WIDTH'(AXI_ID);

    state_e      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [15:0] nb_q, nb_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic [7:0]  beat_q, beat_d;
    logic [31:0] burst_addr_q, burst_addr_d;
    logic [31:0] beat_addr_q, beat_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] first_err_q, first_err_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        wlast_q, wlast_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;

    logic        start_accept_s;
    logic        err_hit_s;
    logic [31:0] err_addr_s;
    logic        last_burst_s;
    logic        rd_bad_s;

    assign last_burst_s = (burst_cnt_q == (nb_q - 16'd1));
    assign rd_bad_s     = (axi.i_rdata != pattern(beat_addr_q))
                       || (axi.i_rresp != AXI_RESP_OKAY)
                       || (axi.i_rlast != (beat_q == LAST_BEAT));

    // Next-state, burst/beat sequencing and error detection.
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        nb_d           = nb_q;
        burst_cnt_d    = burst_cnt_q;
        beat_d         = beat_q;
        burst_addr_d   = burst_addr_q;
        beat_addr_d    = beat_addr_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        start_accept_s = 1'b0;
        err_hit_s      = 1'b0;
        err_addr_s     = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    start_accept_s = 1'b1;
                    base_d         = i_base & ALIGN_MASK;
                    burst_addr_d   = i_base & ALIGN_MASK;
                    beat_addr_d    = i_base & ALIGN_MASK;
                    nb_d           = i_nbursts;
                    burst_cnt_d    = 16'd0;
                    beat_d         = 8'd0;
                    busy_d         = 1'b1;
                    state_d        = (i_nbursts == 16'd0) ? ST_DONE : ST_WR_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                if (axi.i_awready) begin
                    state_d = ST_WR_DATA;
                end else begin
                    state_d = ST_WR_ADDR;
                end
            end
            ST_WR_DATA: begin
                if (axi.i_wready) begin
                    beat_addr_d = beat_addr_q + BEAT_BYTES;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = 8'd0;
                        state_d = ST_WR_RESP;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                    end
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_RESP: begin
                if (axi.i_bvalid) begin
                    err_hit_s  = (axi.i_bresp != AXI_RESP_OKAY) || (axi.i_bid != ID_VAL);
                    err_addr_s = burst_addr_q;
                    if (last_burst_s) begin
                        burst_cnt_d  = 16'd0;
                        burst_addr_d = base_q;
                        beat_addr_d  = base_q;
                        state_d      = ST_RD_ADDR;
                    end else begin
                        burst_cnt_d  = burst_cnt_q + 16'd1;
                        burst_addr_d = beat_addr_q;
                        state_d      = ST_WR_ADDR;
                    end
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_RD_ADDR: begin
                if (axi.i_arready) begin
                    state_d = ST_RD_DATA;
                end else begin
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_DATA: begin
                if (axi.i_rvalid) begin
                    err_hit_s   = rd_bad_s;
                    err_addr_s  = beat_addr_q;
                    beat_addr_d = beat_addr_q + BEAT_BYTES;
                    if (beat_q == LAST_BEAT) begin
                        beat_d = 8'd0;
                        if (last_burst_s) begin
                            state_d = ST_DONE;
                        end else begin
                            burst_cnt_d  = burst_cnt_q + 16'd1;
                            burst_addr_d = beat_addr_q + BEAT_BYTES;
                            state_d      = ST_RD_ADDR;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Channel controls are registered from the upcoming state.
        awvalid_d = (state_d == ST_WR_ADDR);
        wvalid_d  = (state_d == ST_WR_DATA);
        wlast_d   = (state_d == ST_WR_DATA) && (beat_d == LAST_BEAT);
        bready_d  = (state_d == ST_WR_RESP);
        arvalid_d = (state_d == ST_RD_ADDR);
        rready_d  = (state_d == ST_RD_DATA);
    end

    // Error result update: cleared on accepted start, saturating count otherwise.
    always_comb begin
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        if (start_accept_s) begin
            err_cnt_d   = 16'd0;
            first_err_d = 32'd0;
        end else if (err_hit_s) begin
            if (err_cnt_q == 16'd0) begin
                first_err_d = err_addr_s;
            end else begin
                first_err_d = first_err_q;
            end
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            err_cnt_d   = err_cnt_q;
            first_err_d = first_err_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            base_q       <= 32'd0;
            nb_q         <= 16'd0;
            burst_cnt_q  <= 16'd0;
            beat_q       <= 8'd0;
            burst_addr_q <= 32'd0;
            beat_addr_q  <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_cnt_q    <= 16'd0;
            first_err_q  <= 32'd0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wlast_q      <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            nb_q         <= nb_d;
            burst_cnt_q  <= burst_cnt_d;
            beat_q       <= beat_d;
            burst_addr_q <= burst_addr_d;
            beat_addr_q  <= beat_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_cnt_q    <= err_cnt_d;
            first_err_q  <= first_err_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            wlast_q      <= wlast_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
        end
    end

    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_err_count      = err_cnt_q;
    assign o_first_err_addr = first_err_q;

    assign axi.o_awid    = ID_VAL;
    assign axi.o_awaddr  = burst_addr_q;
    assign axi.o_awlen   = LAST_BEAT;
    assign axi.o_awsize  = AXI_SIZE_8B;
    assign axi.o_awburst = AXI_BURST_INCR;
    assign axi.o_awvalid = awvalid_q;

    assign axi.o_wdata   = pattern(beat_addr_q);
    assign axi.o_wstrb   = 8'hFF;
    assign axi.o_wlast   = wlast_q;
    assign axi.o_wvalid  = wvalid_q;

    assign axi.o_bready  = bready_q;

    assign axi.o_arid    = ID_VAL;
    assign axi.o_araddr  = burst_addr_q;
    assign axi.o_arlen   = LAST_BEAT;
    assign axi.o_arsize  = AXI_SIZE_8B;
    assign axi.o_arburst = AXI_BURST_INCR;
    assign axi.o_arvalid = arvalid_q;

    assign axi.o_rready  = rready_q;

endmodule

// File: tb/tb_axi_memtest_master.sv
// Scoreboard bench for axi_memtest_master: a memory slave model with fault
// injection and backpressure; a monitor checks AXI traffic and final results.
module tb_axi_memtest_master;

    localparam int IDW = 6;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [31:0] i_base;
    logic [15:0] i_nbursts;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_err_count;
    logic [31:0] o_first_err_addr;

    axi_memtest_master_if #(.ID_WIDTH(IDW)) axi ();

    axi_memtest_master #(.ID_WIDTH(IDW), .BURST_LEN(8), .AXI_ID(0)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .i_base           (i_base),
        .i_nbursts        (i_nbursts),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_err_count      (o_err_count),
        .o_first_err_addr (o_first_err_addr),
        .axi              (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int w_seen = 0;
    int done_seen = 0;

    logic [31:0] aw_q[$];
    logic [31:0] ar_q[$];
    logic [63:0] w_q[$];
    logic [47:0] res_q[$];

    // slave fault/backpressure configuration, written only by the main process
    bit          cfg_rand = 1'b0;
    bit          cfg_corrupt_en = 1'b0;
    logic [31:0] cfg_corrupt_addr = 32'd0;
    bit          cfg_bresp_en = 1'b0;
    logic [31:0] cfg_bresp_addr = 32'd0;
    bit          cfg_rresp_en = 1'b0;
    logic [31:0] cfg_rresp_addr = 32'd0;

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Memory slave model
    initial begin
        logic [63:0] mem [logic [31:0]];
        bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic [31:0] aw_a, ar_a, s_waddr, s_wburst, s_raddr;
        logic [63:0] w_d;
        logic        w_l;
        logic [7:0]  ar_len;
        int          s_rleft;
        bit          b_pend;
        axi.i_awready = 1'b0; axi.i_wready = 1'b0; axi.i_arready = 1'b0;
        axi.i_bvalid = 1'b0; axi.i_bresp = 2'b00; axi.i_bid = '0;
        axi.i_rvalid = 1'b0; axi.i_rresp = 2'b00; axi.i_rid = '0;
        axi.i_rdata = 64'd0; axi.i_rlast = 1'b0;
        s_waddr = 32'd0; s_wburst = 32'd0; s_raddr = 32'd0; s_rleft = 0; b_pend = 1'b0;
        forever begin
            @(negedge clk);
            aw_hs = !rst && axi.o_awvalid && axi.i_awready; aw_a = axi.o_awaddr;
            w_hs  = !rst && axi.o_wvalid && axi.i_wready;   w_d = axi.o_wdata; w_l = axi.o_wlast;
            b_hs  = !rst && axi.i_bvalid && axi.o_bready;
            ar_hs = !rst && axi.o_arvalid && axi.i_arready; ar_a = axi.o_araddr; ar_len = axi.o_arlen;
            r_hs  = !rst && axi.i_rvalid && axi.o_rready;
            @(posedge clk);
            #1;
            if (rst) begin
                axi.i_awready = 1'b0; axi.i_wready = 1'b0; axi.i_arready = 1'b0;
                axi.i_bvalid = 1'b0; axi.i_rvalid = 1'b0;
                s_rleft = 0; b_pend = 1'b0;
            end else begin
                if (aw_hs) begin s_waddr = aw_a; s_wburst = aw_a; end
                if (w_hs) begin
                    mem[s_waddr] = w_d;
                    s_waddr = s_waddr + 32'd8;
                    if (w_l) b_pend = 1'b1;
                end
                if (b_hs) axi.i_bvalid = 1'b0;
                if (b_pend && !axi.i_bvalid && (!cfg_rand || ($urandom_range(0, 1) == 1))) begin
                    axi.i_bvalid = 1'b1;
                    axi.i_bresp  = (cfg_bresp_en && s_wburst == cfg_bresp_addr) ? 2'b10 : 2'b00;
                    b_pend = 1'b0;
                end
                if (ar_hs) begin s_raddr = ar_a; s_rleft = int'(ar_len) + 1; end
                if (r_hs) begin
                    axi.i_rvalid = 1'b0;
                    s_rleft--;
                    s_raddr = s_raddr + 32'd8;
                end
                if (s_rleft > 0 && !axi.i_rvalid && (!cfg_rand || ($urandom_range(0, 1) == 1))) begin
                    axi.i_rvalid = 1'b1;
                    axi.i_rdata  = mem.exists(s_raddr) ? mem[s_raddr] : 64'd0;
                    if (cfg_corrupt_en && s_raddr == cfg_corrupt_addr) axi.i_rdata = axi.i_rdata ^ 64'd1;
                    axi.i_rresp  = (cfg_rresp_en && s_raddr == cfg_rresp_addr) ? 2'b11 : 2'b00;
                    axi.i_rlast  = (s_rleft == 1);
                end
                axi.i_awready = cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                axi.i_wready  = cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                axi.i_arready = cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Monitor: pops expectations on each handshake/done and checks stability
    initial begin
        bit          aw_p, w_p, ar_p;
        logic [31:0] aw_a, ar_a;
        logic [63:0] w_d;
        logic        w_l;
        int          w_idx;
        logic [47:0] r;
        aw_p = 1'b0; w_p = 1'b0; ar_p = 1'b0; w_idx = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_p = 1'b0; w_p = 1'b0; ar_p = 1'b0; w_idx = 0;
            end else begin
                if (aw_p) begin
                    chk("aw_hold_valid", 64'(axi.o_awvalid), 64'd1);
                    chk("aw_hold_addr", 64'(axi.o_awaddr), 64'(aw_a));
                end
                if (w_p) begin
                    chk("w_hold_valid", 64'(axi.o_wvalid), 64'd1);
                    chk("w_hold_data", axi.o_wdata, w_d);
                    chk("w_hold_last", 64'(axi.o_wlast), 64'(w_l));
                end
                if (ar_p) begin
                    chk("ar_hold_valid", 64'(axi.o_arvalid), 64'd1);
                    chk("ar_hold_addr", 64'(axi.o_araddr), 64'(ar_a));
                end
                if (axi.o_awvalid && axi.i_awready) begin
                    if (aw_q.size() == 0) fail_now("aw_unexpected");
                    else chk("awaddr", 64'(axi.o_awaddr), 64'(aw_q.pop_front()));
                    chk("aw_ctrl", 64'({axi.o_awid, axi.o_awlen, axi.o_awsize, axi.o_awburst}),
                        64'({6'd0, 8'd7, 3'd3, 2'b01}));
                end
                if (axi.o_wvalid && axi.i_wready) begin
                    w_seen++;
                    if (w_q.size() == 0) fail_now("w_unexpected");
                    else chk("wdata", axi.o_wdata, w_q.pop_front());
                    chk("wlast", 64'(axi.o_wlast), 64'(w_idx == 7));
                    chk("wstrb", 64'(axi.o_wstrb), 64'hFF);
                    w_idx = (w_idx + 1) % 8;
                end
                if (axi.o_arvalid && axi.i_arready) begin
                    if (ar_q.size() == 0) fail_now("ar_unexpected");
                    else chk("araddr", 64'(axi.o_araddr), 64'(ar_q.pop_front()));
                    chk("ar_ctrl", 64'({axi.o_arid, axi.o_arlen, axi.o_arsize, axi.o_arburst}),
                        64'({6'd0, 8'd7, 3'd3, 2'b01}));
                end
                if (o_done) begin
                    done_seen++;
                    if (res_q.size() == 0) fail_now("done_unexpected");
                    else begin
                        r = res_q.pop_front();
                        chk("err_count", 64'(o_err_count), 64'(r[47:32]));
                        chk("first_err_addr", 64'(o_first_err_addr), 64'(r[31:0]));
                    end
                    chk("busy_at_done", 64'(o_busy), 64'd0);
                end
                aw_p = axi.o_awvalid && !axi.i_awready; aw_a = axi.o_awaddr;
                w_p  = axi.o_wvalid && !axi.i_wready;   w_d = axi.o_wdata; w_l = axi.o_wlast;
                ar_p = axi.o_arvalid && !axi.i_arready; ar_a = axi.o_araddr;
            end
        end
    end

    task automatic push_exp(input logic [31:0] base, input logic [15:0] nb,
                            input logic [15:0] e_err, input logic [31:0] e_first);
        logic [31:0] al, a;
        al = base & 32'hFFFF_FFC0;
        for (int b = 0; b < int'(nb); b++) begin
            a = al + 32'(b * 64);
            aw_q.push_back(a);
            ar_q.push_back(a);
            for (int i = 0; i < 8; i++) w_q.push_back(pat(a + 32'(i * 8)));
        end
        res_q.push_back({e_err, e_first});
    endtask

    task automatic clear_exp();
        aw_q.delete(); ar_q.delete(); w_q.delete(); res_q.delete();
    endtask

    task automatic run_test(input logic [31:0] base, input logic [15:0] nb,
                            input logic [15:0] e_err, input logic [31:0] e_first,
                            input bit poke, input bit w0_en, input logic [63:0] w0);
        int d0;
        bit ok;
        push_exp(base, nb, e_err, e_first);
        if (w0_en) w_q[0] = w0;
        d0 = done_seen;
        @(posedge clk); #1;
        i_base = base; i_nbursts = nb; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            i_start = 1'b1; i_base = 32'h0000_9000; i_nbursts = 16'd7;
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (done_seen != d0) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("done_timeout");
        @(negedge clk);
        chk("done_one_cycle", 64'(o_done), 64'd0);
        chk("exp_left", 64'(aw_q.size() + ar_q.size() + w_q.size() + res_q.size()), 64'd0);
        clear_exp();
    endtask

    initial begin
        int w0;
        int d0;
        bit ok;
        rst = 1'b1; i_start = 1'b0; i_base = 32'd0; i_nbursts = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valids", 64'({axi.o_awvalid, axi.o_wvalid, axi.o_bready, axi.o_arvalid, axi.o_rready}), 64'd0);
        chk("rst_busy_done", 64'({o_busy, o_done}), 64'd0);
        chk("rst_err", 64'({o_err_count, o_first_err_addr}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ideal slave, start-while-busy ignored, hand-computed first beat
        run_test(32'h0000_1000, 16'd2, 16'd0, 32'd0, 1'b1, 1'b1, 64'hFFFF_EFFF_0000_1000);

        cfg_corrupt_en = 1'b1; cfg_corrupt_addr = 32'h0000_1058;
        run_test(32'h0000_1000, 16'd2, 16'd1, 32'h0000_1058, 1'b0, 1'b0, 64'd0);
        cfg_corrupt_en = 1'b0;

        cfg_rand = 1'b1;
        run_test(32'h0003_0000, 16'd16, 16'd0, 32'd0, 1'b0, 1'b0, 64'd0);
        cfg_rand = 1'b0;

        cfg_bresp_en = 1'b1; cfg_bresp_addr = 32'h0000_2000;
        cfg_rresp_en = 1'b1; cfg_rresp_addr = 32'h0000_2050;
        run_test(32'h0000_2000, 16'd2, 16'd2, 32'h0000_2000, 1'b0, 1'b0, 64'd0);
        cfg_bresp_en = 1'b0; cfg_rresp_en = 1'b0;

        // reset while W beat 4 is being presented
        push_exp(32'h0000_1000, 16'd2, 16'd0, 32'd0);
        w0 = w_seen;
        @(posedge clk); #1;
        i_base = 32'h0000_1000; i_nbursts = 16'd2; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (w_seen >= w0 + 4) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("wbeat4_timeout");
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valids", 64'({axi.o_awvalid, axi.o_wvalid, axi.o_bready, axi.o_arvalid, axi.o_rready}), 64'd0);
        chk("midrst_busy_done", 64'({o_busy, o_done}), 64'd0);
        chk("midrst_err", 64'({o_err_count, o_first_err_addr}), 64'd0);
        clear_exp();
        @(posedge clk); #1;
        rst = 1'b0;
        run_test(32'h0000_4000, 16'd1, 16'd0, 32'd0, 1'b0, 1'b0, 64'd0);

        // zero bursts: done two cycles after the start sample, start held while busy
        res_q.push_back({16'd0, 32'd0});
        d0 = done_seen;
        @(posedge clk); #1;
        i_base = 32'h0000_5000; i_nbursts = 16'd0; i_start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("nb0_c1_busy_done", 64'({o_busy, o_done}), 64'b10);
        chk("nb0_c1_valids", 64'({axi.o_awvalid, axi.o_wvalid, axi.o_arvalid}), 64'd0);
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        chk("nb0_c2_busy_done", 64'({o_busy, o_done}), 64'b01);
        chk("nb0_c2_valids", 64'({axi.o_awvalid, axi.o_wvalid, axi.o_arvalid}), 64'd0);
        @(negedge clk);
        chk("nb0_c3_busy_done", 64'({o_busy, o_done}), 64'b00);
        chk("nb0_done_count", 64'(done_seen - d0), 64'd1);
        clear_exp();

        // unaligned base forced down to 64-byte boundary, wrapping past 2^32
        run_test(32'hFFFF_FFE5, 16'd2, 16'd0, 32'd0, 1'b0, 1'b0, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
